// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined logarithmic barrel shifter with valid/ready flow control
module shifter_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAGW      = 4,
  localparam int SHW = $clog2(WIDTH),
  localparam int LAT = (SHW + REG_EVERY - 1) / REG_EVERY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW:0]     in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             busy
);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Applies the 2^k shift stages whose index lies in [lo, hi).
  function automatic logic [WIDTH-1:0] shiftRange(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] op,
                                                  input logic [SHW-1:0] amt,
                                                  input int lo, input int hi);
    logic [WIDTH-1:0] r;
    int s;
    r = d;
    for (int k = 0; k < SHW; k++) begin
      s = 1 << k;
      if (k >= lo && k < hi && amt[k]) begin
        case (op)
          OP_SLL:  r = r << s;
          OP_SRL:  r = r >> s;
          OP_SRA:  r = $signed(r) >>> s;
          default: r = (r >> s) | (r << (WIDTH - s));
        endcase
      end
    end
    return r;
  endfunction

  logic [LAT-1:0]   validQ;
  logic [LAT-1:0]   loadVec;
  logic [WIDTH-1:0] dataQ    [LAT];
  logic [TAGW-1:0]  tagQ     [LAT];
  logic [1:0]       opQ      [LAT];
  logic [SHW-1:0]   shamtQ   [LAT];
  logic             oorQ     [LAT];

  logic [LAT-1:0]   srcValid;
  logic [WIDTH-1:0] srcData  [LAT];
  logic [TAGW-1:0]  srcTag   [LAT];
  logic [1:0]       srcOp    [LAT];
  logic [SHW-1:0]   srcShamt [LAT];
  logic             srcOor   [LAT];
  logic [WIDTH-1:0] nextData [LAT];

  // Out-of-range SLL/SRL/SRA collapse to a constant up front; later stages preserve it.
  always_comb begin
    srcValid[0] = in_valid;
    srcData[0]  = in_data;
    if (in_shamt[SHW] && in_op != OP_ROR)
      srcData[0] = (in_op == OP_SRA) ? {WIDTH{in_data[WIDTH-1]}} : '0;
    srcTag[0]   = in_tag;
    srcOp[0]    = in_op;
    srcShamt[0] = in_shamt[SHW-1:0];
    srcOor[0]   = in_shamt[SHW];
    for (int i = 1; i < LAT; i++) begin
      srcValid[i] = validQ[i-1];
      srcData[i]  = dataQ[i-1];
      srcTag[i]   = tagQ[i-1];
      srcOp[i]    = opQ[i-1];
      srcShamt[i] = shamtQ[i-1];
      srcOor[i]   = oorQ[i-1];
    end
    for (int i = 0; i < LAT; i++)
      nextData[i] = shiftRange(srcData[i], srcOp[i], srcShamt[i],
                               i * REG_EVERY, (i + 1) * REG_EVERY);
  end

  // A stage may load when empty or when everything downstream can move.
  always_comb begin
    logic dn;
    dn = out_ready;
    for (int i = LAT - 1; i >= 0; i--) begin
      loadVec[i] = !validQ[i] || dn;
      dn         = loadVec[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ <= '0;
      for (int i = 0; i < LAT; i++) begin
        dataQ[i]  <= '0;
        tagQ[i]   <= '0;
        opQ[i]    <= '0;
        shamtQ[i] <= '0;
        oorQ[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        if (loadVec[i]) begin
          validQ[i] <= srcValid[i];
          if (srcValid[i]) begin
            dataQ[i]  <= nextData[i];
            tagQ[i]   <= srcTag[i];
            opQ[i]    <= srcOp[i];
            shamtQ[i] <= srcShamt[i];
            oorQ[i]   <= srcOor[i];
          end
        end
      end
    end
  end

  assign in_ready  = loadVec[0];
  assign out_valid = validQ[LAT-1];
  assign out_data  = dataQ[LAT-1];
  assign out_tag   = tagQ[LAT-1];
  assign busy      = |validQ;
endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - directed-vector bench for shifter_pipe (LAT=5 and LAT=1 builds)
module tb_shifter_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inValid, inValidB, inReady, inReadyB;
  logic [31:0] inData;
  logic [5:0]  inShamt;
  logic [1:0]  inOp;
  logic [3:0]  inTag;
  logic        outValid, outReady, outValidB, outReadyB;
  logic [31:0] outData, outDataB;
  logic [3:0]  outTag, outTagB;
  logic        busy, busyB;
  int nVec = 0;
  int nMis = 0;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  sh;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  shifter_pipe #(.WIDTH(32), .REG_EVERY(1), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_shamt(inShamt), .in_op(inOp), .in_tag(inTag), .out_valid(outValid),
    .out_ready(outReady), .out_data(outData), .out_tag(outTag), .busy(busy));

  shifter_pipe #(.WIDTH(32), .REG_EVERY(5), .TAGW(4)) dutB (
    .clk(clk), .rst(rst), .in_valid(inValidB), .in_ready(inReadyB), .in_data(inData),
    .in_shamt(inShamt), .in_op(inOp), .in_tag(inTag), .out_valid(outValidB),
    .out_ready(outReadyB), .out_data(outDataB), .out_tag(outTagB), .busy(busyB));

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b0; inValidB = 1'b0; inData = '0; inShamt = '0;
    inOp = '0; inTag = '0; outReady = 1'b1; outReadyB = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nVec++;
    if ({outValid, busy, inReady, outData, outTag} !== {1'b0, 1'b0, 1'b1, 32'h0, 4'h0}) begin
      nMis++;
      $display("FAIL reset_state: got v=%b busy=%b rdy=%b data=%h tag=%h expected 0 0 1 0 0",
               outValid, busy, inReady, outData, outTag);
    end
    nVec++;
    if ({outValidB, busyB, inReadyB} !== 3'b001) begin
      nMis++;
      $display("FAIL reset_state_b: got %b expected 001", {outValidB, busyB, inReadyB});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    nVec++;
    if (inReady !== 1'b1) begin
      nMis++;
      $display("FAIL ready_after_reset: got %b expected 1", inReady);
    end
  endtask

  task automatic test_ops();
    vec_t v[12];
    int n, latA, latB;
    logic [31:0] dA, dB;
    logic [3:0]  tA;
    v[0]  = '{2'b00, 6'd31,      32'h0000_0001, 32'h8000_0000};
    v[1]  = '{2'b10, 6'd4,       32'h8000_0000, 32'hF800_0000};
    v[2]  = '{2'b00, 6'b100000,  32'hFFFF_FFFF, 32'h0000_0000};
    v[3]  = '{2'b01, 6'b100000,  32'hFFFF_FFFF, 32'h0000_0000};
    v[4]  = '{2'b10, 6'b100000,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v[5]  = '{2'b11, 6'b100100,  32'h1234_5678, 32'h8123_4567};
    v[6]  = '{2'b01, 6'd4,       32'h8000_0000, 32'h0800_0000};
    v[7]  = '{2'b11, 6'd1,       32'h0000_0001, 32'h8000_0000};
    v[8]  = '{2'b10, 6'd31,      32'h7FFF_FFFF, 32'h0000_0000};
    v[9]  = '{2'b00, 6'd0,       32'h1234_5678, 32'h1234_5678};
    v[10] = '{2'b00, 6'd8,       32'hDEAD_BEEF, 32'hADBE_EF00};
    v[11] = '{2'b11, 6'd16,      32'hDEAD_BEEF, 32'hBEEF_DEAD};
    for (int i = 0; i < 12; i++) begin
      inOp = v[i].op; inShamt = v[i].sh; inData = v[i].d; inTag = i[3:0];
      inValid = 1'b1; inValidB = 1'b1;
      #1;
      nVec++;
      if ({inReady, inReadyB} !== 2'b11) begin
        nMis++;
        $display("FAIL ops_ready[%0d]: got %b expected 11", i, {inReady, inReadyB});
      end
      @(posedge clk);
      #1;
      inValid = 1'b0; inValidB = 1'b0;
      n = 1; latA = -1; latB = -1; dA = 'x; dB = 'x; tA = 'x;
      while ((latA < 0 || latB < 0) && n < 20) begin
        #1;
        if (latB < 0 && outValidB) begin latB = n; dB = outDataB; end
        if (latA < 0 && outValid) begin latA = n; dA = outData; tA = outTag; end
        if (latA < 0 || latB < 0) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
      nVec++;
      if (latA != 5 || dA !== v[i].exp || tA !== i[3:0]) begin
        nMis++;
        $display("FAIL ops_lat5[%0d]: got lat=%0d data=%h tag=%h expected lat=5 data=%h tag=%h",
                 i, latA, dA, tA, v[i].exp, i[3:0]);
      end
      nVec++;
      if (latB != 1 || dB !== v[i].exp) begin
        nMis++;
        $display("FAIL ops_lat1[%0d]: got lat=%0d data=%h expected lat=1 data=%h",
                 i, latB, dB, v[i].exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int first, last, cnt;
    first = -1; last = -1; cnt = 0;
    outReady = 1'b1; inOp = 2'b00; inShamt = 6'd4;
    for (int c = 0; c < 30; c++) begin
      inValid = (c < 8); inTag = c[3:0]; inData = 32'h100 + c;
      #1;
      if (c < 8) begin
        nVec++;
        if (inReady !== 1'b1) begin
          nMis++;
          $display("FAIL b2b_ready[%0d]: got %b expected 1", c, inReady);
        end
      end
      if (outValid && cnt < 8) begin
        if (first < 0) first = c;
        last = c;
        nVec++;
        if (outTag !== cnt[3:0] || outData !== (32'h1000 + (32'(cnt) << 4))) begin
          nMis++;
          $display("FAIL b2b_result[%0d]: got tag=%h data=%h expected tag=%h data=%h",
                   cnt, outTag, outData, cnt[3:0], 32'h1000 + (32'(cnt) << 4));
        end
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    nVec++;
    if (cnt != 8 || first != 5 || last - first != 7) begin
      nMis++;
      $display("FAIL b2b_stream: got count=%0d first=%0d last=%0d expected 8 5 12", cnt, first, last);
    end
  endtask

  task automatic test_backpressure();
    int accepts, got;
    logic haveRef;
    logic [31:0] refData;
    logic [3:0]  refTag;
    accepts = 0; haveRef = 1'b0; refData = '0; refTag = '0;
    outReady = 1'b0; inOp = 2'b00; inShamt = 6'd4;
    for (int c = 0; c < 10; c++) begin
      inValid = 1'b1; inTag = accepts[3:0]; inData = 32'(accepts) + 32'd1;
      #1;
      if (inReady) accepts++;
      if (outValid) begin
        if (!haveRef) begin
          haveRef = 1'b1; refData = outData; refTag = outTag;
        end else begin
          nVec++;
          if (outData !== refData || outTag !== refTag) begin
            nMis++;
            $display("FAIL bp_stable[%0d]: got data=%h tag=%h expected data=%h tag=%h",
                     c, outData, outTag, refData, refTag);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    #1;
    nVec++;
    if (accepts != 5 || inReady !== 1'b0 || refData !== 32'h10 || refTag !== 4'h0) begin
      nMis++;
      $display("FAIL bp_full: got accepts=%0d rdy=%b head=%h/%h expected 5 0 00000010/0",
               accepts, inReady, refData, refTag);
    end
    got = 0;
    outReady = 1'b1;
    for (int c = 0; c < 20 && got < 6; c++) begin
      inValid = (c == 0); inTag = 4'd5; inData = 32'd6;
      #1;
      if (c == 0) begin
        nVec++;
        if (inReady !== 1'b1) begin
          nMis++;
          $display("FAIL bp_same_cycle_accept: got rdy=%b expected 1", inReady);
        end
      end
      if (outValid) begin
        nVec++;
        if (outTag !== got[3:0] || outData !== ((32'(got) + 32'd1) << 4)) begin
          nMis++;
          $display("FAIL bp_drain[%0d]: got tag=%h data=%h expected tag=%h data=%h",
                   got, outTag, outData, got[3:0], (32'(got) + 32'd1) << 4);
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    nVec++;
    if (got != 6) begin
      nMis++;
      $display("FAIL bp_drain_count: got %0d expected 6", got);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale = 0;
    outReady = 1'b1; inOp = 2'b01; inShamt = 6'd1;
    for (int c = 0; c < 3; c++) begin
      inValid = 1'b1; inTag = 4'd9 + c[3:0]; inData = 32'hF0 + c;
      @(posedge clk);
      #1;
    end
    nVec++;
    if (busy !== 1'b1) begin
      nMis++;
      $display("FAIL mid_busy_before: got %b expected 1", busy);
    end
    inTag = 4'hF;
    rst = 1'b1;
    #1;
    nVec++;
    if ({outValid, busy, inReady} !== 3'b001) begin
      nMis++;
      $display("FAIL mid_reset_async: got v/busy/rdy=%b expected 001", {outValid, busy, inReady});
    end
    @(posedge clk);
    #1;
    nVec++;
    if (busy !== 1'b0) begin
      nMis++;
      $display("FAIL mid_no_accept_in_reset: got busy=%b expected 0", busy);
    end
    rst = 1'b0; inValid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (outValid !== 1'b0 || busy !== 1'b0) stale++;
    end
    nVec++;
    if (stale != 0) begin
      nMis++;
      $display("FAIL mid_no_stale: got %0d cycles with activity expected 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width; legal values are powers of 2 from 8 to 64.
REQ-002 SHALL have parameter REG_EVERY, default 1, meaning shift stages per pipeline register; legal range 1..log2(WIDTH).
REQ-003 SHALL have parameter TAGW, default 4, meaning sideband tag width carried alongside data.
REQ-004 SHALL have derived constants SHW = log2(WIDTH) and LAT = ceil(SHW/REG_EVERY); LAT is the number of pipeline registers.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-009 SHALL have port in_data  input  WIDTH  operand.
REQ-010 SHALL have port in_shamt  input  SHW+1  shift amount; MSB is the out-of-range flag.
REQ-011 SHALL have port in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-012 SHALL have port in_tag  input  TAGW  opaque sideband, returned unchanged.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  consumer takes the result when out_valid and out_ready are both high at a clk edge.
REQ-015 SHALL have port out_data  output  WIDTH  result.
REQ-016 SHALL have port out_tag  output  TAGW  tag of the result.
REQ-017 SHALL have port busy  output  1  high when any stage holds a valid entry.

Function
REQ-018 SHALL implement SHW logarithmic stages; stage k conditionally shifts by 2^k per in_shamt[k], LSB stage first.
REQ-019 SHALL place a register after every REG_EVERY stages and after the last stage, giving LAT registers in total; the last register drives out_*.
REQ-020 SHALL apply the SLL rule: fill vacated LSBs with 0.
REQ-021 SHALL apply the SRL rule: fill vacated MSBs with 0.
REQ-022 SHALL apply the SRA rule: fill vacated MSBs with in_data[WIDTH-1].
REQ-023 SHALL apply the ROR rule: bits shifted out of the LSB re-enter at the MSB.
REQ-024 SHALL, when in_shamt[SHW]=1, produce all-zero for SLL/SRL, all copies of the sign bit for SRA, and for ROR ignore the MSB and rotate by in_shamt[SHW-1:0].
REQ-025 SHALL carry op, the out-of-range flag, the remaining shamt bits and the tag with each entry through every register.
REQ-026 SHALL give each register stage i a valid bit; stage i SHALL load when !valid_i or stage i+1 advances (for the last stage: out_ready).
REQ-027 SHALL drive in_ready combinationally as !valid_0 or stage 0 advancing, so bubbles collapse.
REQ-028 SHALL, with out_ready held high, present a result LAT cycles after acceptance and sustain one result per cycle.
REQ-029 SHALL, when out_valid=1 and out_ready=0, hold out_data/out_tag stable, and upstream stages SHALL fill until all are valid, then deassert in_ready.
REQ-030 SHALL, on a simultaneous out_ready handshake and in_valid with a full pipe, accept the new entry in the same cycle (no lost slot).
REQ-031 SHALL deliver results in acceptance order with no drops or duplicates.
REQ-032 SHALL ignore in_data/in_shamt/in_op/in_tag in cycles with no handshake.
REQ-033 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-034 SHALL, while rst=1, asynchronously clear all valid bits and all data/tag registers to 0; out_valid=0, out_data=0, out_tag=0, busy=0.
REQ-035 SHALL drive in_ready=1 during and immediately after reset.
REQ-036 SHALL discard in-flight entries on reset mid-operation and produce no result for them after rst falls.
REQ-037 SHALL accept no entry in a cycle where rst=1.

Verification (WIDTH=32, REG_EVERY=1, LAT=5, out_ready=1 unless stated)
REQ-038 SHALL cover: SLL 0x0000_0001 by 31 -> 0x8000_0000 exactly 5 cycles after accept; SRA 0x8000_0000 by 4 -> 0xF800_0000.
REQ-039 SHALL cover: shamt=6'b100000 with data 0xFFFF_FFFF -> SLL/SRL 0x0, SRA 0xFFFF_FFFF; ROR 0x1234_5678 by 6'b100100 -> 0x8123_4567.
REQ-040 SHALL cover: back-to-back 8 requests with tags 0..7 -> 8 consecutive out_valid cycles, tags in order 0..7.
REQ-041 SHALL cover: out_ready=0 for 10 cycles while streaming -> in_ready low after 5 accepts, out_data stable; on release all 5 drain in order.
REQ-042 SHALL cover: rst pulse with 3 entries in flight -> out_valid=0 and busy=0 immediately, no stale result afterward.
REQ-043 SHALL cover: REG_EVERY=5 build -> LAT=1, single-cycle latency, same results as REQ-038.
